// File: rtl/qpi_rd_stream.sv
// Tagged QPI cache-line read streamer: issues up to TAGS outstanding reads, reorders
// responses and delivers lines in order. Optional stall counter: QPI_RD_STREAM_PERF_EN.
module qpi_rd_stream #(
  parameter int TAGS   = 8,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_base_addr,
  input  logic [ADDR_W-1:0] io_num_lines,
  input  logic              io_qpi_rd_req_almostfull,
  output logic [ADDR_W-1:0] io_qpi_rd_req_addr,
  output logic [13:0]       io_qpi_rd_req_mdata,
  output logic              io_qpi_rd_req_valid,
  input  logic [13:0]       io_qpi_rd_rsp_mdata,
  input  logic [511:0]      io_qpi_rd_rsp_data,
  input  logic              io_qpi_rd_rsp_valid,
  output logic              io_out_valid,
  output logic [511:0]      io_out_data,
  input  logic              io_out_ready,
  output logic              io_busy,
  output logic              io_done
`ifdef QPI_RD_STREAM_PERF_EN
  ,
  output logic [31:0]       io_stall_cycles
`endif
);

  localparam int TAG_W  = $clog2(TAGS);
  localparam int LINE_W = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   num_q;
  logic [ADDR_W-1:0]   issued_q;
  logic [ADDR_W-1:0]   delivered_q;
  logic [TAGS-1:0]     full_q;
  logic [LINE_W-1:0]   slot_data [TAGS];

  logic [TAG_W-1:0]    head;
  logic [TAG_W-1:0]    rsp_tag;
  logic [TAG_W-1:0]    rsp_off;
  logic [ADDR_W-1:0]   outstanding;
  logic [ADDR_W-1:0]   delivered_nxt;
  logic                want_issue;
  logic                issue;
  logic                rsp_expected;
  logic                rsp_accept;
  logic                pop;
  logic                last_pop;
  logic                unused_mdata;

  // Head slot is the delivery count modulo TAGS, so it needs no separate register.
  assign head          = delivered_q[TAG_W-1:0];
  assign outstanding   = issued_q - delivered_q;
  assign want_issue    = (state == RUN) && (issued_q < num_q);
  assign issue         = want_issue && !io_qpi_rd_req_almostfull &&
                         (outstanding < ADDR_W'(TAGS));

  assign io_qpi_rd_req_valid = issue;
  assign io_qpi_rd_req_addr  = base_q + issued_q;
  assign io_qpi_rd_req_mdata = {{(14-TAG_W){1'b0}}, issued_q[TAG_W-1:0]};

  // A response is only taken for a tag inside the live window; anything else
  // (stale traffic after a reset, or a repeat to a full slot) is dropped.
  assign rsp_tag       = io_qpi_rd_rsp_mdata[TAG_W-1:0];
  assign rsp_off       = rsp_tag - head;
  assign rsp_expected  = ADDR_W'(rsp_off) < outstanding;
  assign rsp_accept    = io_qpi_rd_rsp_valid && (state == RUN) && rsp_expected &&
                         !full_q[rsp_tag];
  assign unused_mdata  = ^io_qpi_rd_rsp_mdata[13:TAG_W];

  assign io_out_valid  = full_q[head];
  assign io_out_data   = io_out_valid ? slot_data[head] : '0;
  assign pop           = io_out_valid && io_out_ready;
  assign delivered_nxt = delivered_q + ADDR_W'(pop);
  assign last_pop      = (issued_q == num_q) && (delivered_nxt == num_q);

  assign io_busy       = busy_q;
  assign io_done       = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_start) begin
            base_q      <= io_base_addr;
            num_q       <= io_num_lines;
            issued_q    <= '0;
            delivered_q <= '0;
            busy_q      <= 1'b1;
            if (io_num_lines == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) issued_q <= issued_q + 1'b1;
          delivered_q <= delivered_nxt;
          if (last_pop) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // A full slot never accepts a response, so the set and clear below never
  // target the same slot in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
    end else begin
      if (pop)        full_q[head]    <= 1'b0;
      if (rsp_accept) full_q[rsp_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_accept) slot_data[rsp_tag] <= io_qpi_rd_rsp_data;
  end

`ifdef QPI_RD_STREAM_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state == IDLE && io_start) begin
      stall_q <= '0;
    end else if (want_issue && !issue) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign io_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_qpi_rd_stream.sv
// Randomized bench for qpi_rd_stream against a line-index level reference model.
module tb_qpi_rd_stream;
  localparam int TAGS   = 8;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_start;
  logic [ADDR_W-1:0] io_base_addr;
  logic [ADDR_W-1:0] io_num_lines;
  logic              io_qpi_rd_req_almostfull;
  logic [ADDR_W-1:0] io_qpi_rd_req_addr;
  logic [13:0]       io_qpi_rd_req_mdata;
  logic              io_qpi_rd_req_valid;
  logic [13:0]       io_qpi_rd_rsp_mdata;
  logic [511:0]      io_qpi_rd_rsp_data;
  logic              io_qpi_rd_rsp_valid;
  logic              io_out_valid;
  logic [511:0]      io_out_data;
  logic              io_out_ready;
  logic              io_busy;
  logic              io_done;
`ifdef QPI_RD_STREAM_PERF_EN
  logic [31:0]       io_stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  qpi_rd_stream #(.TAGS(TAGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .io_start(io_start),
    .io_base_addr(io_base_addr),
    .io_num_lines(io_num_lines),
    .io_qpi_rd_req_almostfull(io_qpi_rd_req_almostfull),
    .io_qpi_rd_req_addr(io_qpi_rd_req_addr),
    .io_qpi_rd_req_mdata(io_qpi_rd_req_mdata),
    .io_qpi_rd_req_valid(io_qpi_rd_req_valid),
    .io_qpi_rd_rsp_mdata(io_qpi_rd_rsp_mdata),
    .io_qpi_rd_rsp_data(io_qpi_rd_rsp_data),
    .io_qpi_rd_rsp_valid(io_qpi_rd_rsp_valid),
    .io_out_valid(io_out_valid),
    .io_out_data(io_out_data),
    .io_out_ready(io_out_ready),
    .io_busy(io_busy),
    .io_done(io_done)
`ifdef QPI_RD_STREAM_PERF_EN
    , .io_stall_cycles(io_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [13:0] tag_mdata(input int idx);
    logic [13:0] m;
    m = 14'($urandom) & ~14'(TAGS - 1);
    return m | 14'(idx % TAGS);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    io_start = 1'b0; io_base_addr = '0; io_num_lines = '0;
    io_qpi_rd_req_almostfull = 1'b0; io_qpi_rd_rsp_valid = 1'b0;
    io_qpi_rd_rsp_mdata = '0; io_qpi_rd_rsp_data = '0; io_out_ready = 1'b0;
    #12;
    n_cmp++;
    if ({io_qpi_rd_req_valid, io_out_valid, io_done, io_busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs got req/out/done/busy=%b required 0000",
               {io_qpi_rd_req_valid, io_out_valid, io_done, io_busy});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (io_busy !== 1'b0 || io_qpi_rd_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got busy=%b valid=%b required 0/0", io_busy, io_qpi_rd_req_valid);
    end
  endtask

  // Reference: line i is requested at base+i with tag i%TAGS; lines leave in index order.
  task automatic test_stream(input logic [ADDR_W-1:0] base, input int lines, input bit ooo,
                             input bit rand_rdy, input bit rand_af, input int hold_rdy,
                             input int af_lo, input int af_hi);
    logic [511:0]      ldata [64];
    bit                arr [64];
    int                pend[$];
    int                iss, del, cyc, stalls, idx, k, obs_req, exp_req;
    bit                af, rdy, rv, ev, eov;
    logic [511:0]      rd;
    logic [ADDR_W-1:0] ea;
    for (int i = 0; i < 64; i++) begin ldata[i] = rand_line(); arr[i] = 1'b0; end
    @(negedge clk);
    io_start = 1'b1; io_base_addr = base; io_num_lines = ADDR_W'(lines);
    io_qpi_rd_req_almostfull = 1'b0; io_out_ready = 1'b0; io_qpi_rd_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (io_busy !== 1'b0 || io_qpi_rd_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL start_idle got busy=%b valid=%b required 0/0", io_busy, io_qpi_rd_req_valid);
    end
    iss = 0; del = 0; cyc = 0; stalls = 0; obs_req = 0;
    while (del < lines && cyc < 3000) begin
      @(negedge clk);
      io_start = ($urandom_range(0, 7) == 0);
      io_base_addr = ADDR_W'($urandom); io_num_lines = ADDR_W'($urandom);
      af = rand_af ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (cyc >= af_lo && cyc <= af_hi) af = 1'b1;
      rdy = (cyc < hold_rdy) ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      rv = 1'b0; rd = '0; idx = 0;
      if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = ooo ? int'($urandom_range(0, pend.size() - 1)) : 0;
        idx = pend[k]; pend.delete(k); rv = 1'b1; rd = ldata[idx];
      end else if (iss > del && $urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(del, iss - 1));
        if (arr[idx]) begin rv = 1'b1; rd = rand_line(); end
      end
      io_qpi_rd_req_almostfull = af; io_out_ready = rdy;
      io_qpi_rd_rsp_valid = rv; io_qpi_rd_rsp_data = rd; io_qpi_rd_rsp_mdata = tag_mdata(idx);
      #1;
      ev  = (iss < lines) && !af && (iss - del < TAGS);
      eov = arr[del];
      ea  = base + ADDR_W'(iss);
      n_cmp++;
      if (io_qpi_rd_req_valid !== ev) begin
        n_err++;
        $display("FAIL req_valid cyc=%0d got %b required %b", cyc, io_qpi_rd_req_valid, ev);
      end
      if (io_qpi_rd_req_valid === 1'b1) obs_req++;
      if (ev) begin
        n_cmp++;
        if (io_qpi_rd_req_addr !== ea || io_qpi_rd_req_mdata !== 14'(iss % TAGS)) begin
          n_err++;
          $display("FAIL req_fields line=%0d got addr=%h mdata=%0d required addr=%h mdata=%0d",
                   iss, io_qpi_rd_req_addr, io_qpi_rd_req_mdata, ea, iss % TAGS);
        end
      end
      n_cmp++;
      if (io_out_valid !== eov) begin
        n_err++;
        $display("FAIL out_valid cyc=%0d line=%0d got %b required %b", cyc, del, io_out_valid, eov);
      end
      if (eov) begin
        n_cmp++;
        if (io_out_data !== ldata[del]) begin
          n_err++;
          $display("FAIL out_data line=%0d got %h required %h", del, io_out_data, ldata[del]);
        end
      end
      n_cmp++;
      if (io_busy !== 1'b1 || io_done !== 1'b0) begin
        n_err++;
        $display("FAIL run_status got busy=%b done=%b required 1/0", io_busy, io_done);
      end
      if (iss < lines && !ev) stalls++;
      @(posedge clk);
      if (ev) begin pend.push_back(iss); iss++; end
      if (rv) arr[idx] = 1'b1;
      if (eov && rdy) del++;
      if (hold_rdy > 0 && cyc == hold_rdy - 1) begin
        exp_req = (lines < TAGS) ? lines : TAGS;
        n_cmp++;
        if (obs_req != exp_req) begin
          n_err++;
          $display("FAIL window_limit got %0d requests required %0d", obs_req, exp_req);
        end
      end
      cyc++;
    end
    if (cyc >= 3000) begin
      n_err++;
      $display("FAIL stream_timeout delivered %0d required %0d", del, lines);
    end
    @(negedge clk);
    io_start = 1'b0; io_qpi_rd_rsp_valid = 1'b0; io_out_ready = 1'b0;
    io_qpi_rd_req_almostfull = 1'b0;
    #1;
    n_cmp++;
    if ({io_done, io_busy, io_qpi_rd_req_valid, io_out_valid} !== 4'b1100) begin
      n_err++;
      $display("FAIL done_pulse got done/busy/req/out=%b required 1100",
               {io_done, io_busy, io_qpi_rd_req_valid, io_out_valid});
    end
`ifdef QPI_RD_STREAM_PERF_EN
    n_cmp++;
    if (io_stall_cycles !== 32'(stalls)) begin
      n_err++;
      $display("FAIL stall_cycles got %0d required %0d", io_stall_cycles, stalls);
    end
`endif
    @(negedge clk);
    #1;
    n_cmp++;
    if (io_done !== 1'b0 || io_busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_clear got done=%b busy=%b required 0/0", io_done, io_busy);
    end
  endtask

  task automatic test_out_of_order();
    logic [511:0] ld [4];
    int order [4] = '{3, 1, 2, 0};
    for (int i = 0; i < 4; i++) ld[i] = rand_line();
    @(negedge clk);
    io_start = 1'b1; io_base_addr = 20'h2000; io_num_lines = 20'd4;
    io_qpi_rd_req_almostfull = 1'b0; io_out_ready = 1'b1; io_qpi_rd_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io_start = 1'b0;
      #1;
      n_cmp++;
      if (io_qpi_rd_req_valid !== 1'b1 || io_qpi_rd_req_mdata !== 14'(i)) begin
        n_err++;
        $display("FAIL ooo_issue %0d got valid=%b mdata=%0d required 1/%0d",
                 i, io_qpi_rd_req_valid, io_qpi_rd_req_mdata, i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io_qpi_rd_rsp_valid = 1'b1; io_qpi_rd_rsp_mdata = tag_mdata(order[i]);
      io_qpi_rd_rsp_data = ld[order[i]];
      #1;
      n_cmp++;
      if (io_out_valid !== 1'b0 || io_qpi_rd_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ooo_wait step=%0d got out=%b req=%b required 0/0",
                 i, io_out_valid, io_qpi_rd_req_valid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io_qpi_rd_rsp_valid = 1'b0;
      #1;
      n_cmp++;
      if (io_out_valid !== 1'b1 || io_out_data !== ld[i]) begin
        n_err++;
        $display("FAIL ooo_out line=%0d got valid=%b data=%h required 1/%h",
                 i, io_out_valid, io_out_data, ld[i]);
      end
    end
    @(negedge clk);
    io_out_ready = 1'b0;
    #1;
    n_cmp++;
    if (io_done !== 1'b1) begin
      n_err++;
      $display("FAIL ooo_done got %b required 1", io_done);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_lines();
    @(negedge clk);
    io_start = 1'b1; io_base_addr = 20'h0ABC; io_num_lines = '0;
    io_qpi_rd_req_almostfull = 1'b0; io_out_ready = 1'b1; io_qpi_rd_rsp_valid = 1'b0;
    @(negedge clk);
    io_start = 1'b1; io_num_lines = 20'd5;
    #1;
    n_cmp++;
    if ({io_done, io_busy, io_qpi_rd_req_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL zero_done got done/busy/req=%b required 110", {io_done, io_busy, io_qpi_rd_req_valid});
    end
    @(negedge clk);
    io_start = 1'b0;
    #1;
    n_cmp++;
    if (io_done !== 1'b0 || io_busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_ignore_start got done=%b busy=%b required 0/0", io_done, io_busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (io_qpi_rd_req_valid !== 1'b0 || io_busy !== 1'b0) begin
        n_err++;
        $display("FAIL zero_idle cyc=%0d got req=%b busy=%b required 0/0", i, io_qpi_rd_req_valid, io_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    io_start = 1'b1; io_base_addr = 20'h0300; io_num_lines = 20'd10;
    io_qpi_rd_req_almostfull = 1'b0; io_out_ready = 1'b0; io_qpi_rd_rsp_valid = 1'b0;
    @(negedge clk);
    io_start = 1'b0;
    @(negedge clk);
    io_qpi_rd_rsp_valid = 1'b1; io_qpi_rd_rsp_mdata = 14'd0; io_qpi_rd_rsp_data = rand_line();
    @(negedge clk);
    io_qpi_rd_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (io_out_valid !== 1'b1 || io_busy !== 1'b1 || io_qpi_rd_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_before got out=%b busy=%b req=%b required 1/1/1",
               io_out_valid, io_busy, io_qpi_rd_req_valid);
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({io_qpi_rd_req_valid, io_out_valid, io_done, io_busy} !== 4'b0000 ||
        io_out_data !== '0 || io_qpi_rd_req_addr !== '0) begin
      n_err++;
      $display("FAIL mid_reset got req/out/done/busy=%b addr=%h required 0000/0",
               {io_qpi_rd_req_valid, io_out_valid, io_done, io_busy}, io_qpi_rd_req_addr);
    end
    @(negedge clk);
    reset = 1'b1; io_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      io_qpi_rd_rsp_valid = (i < 4); io_qpi_rd_rsp_mdata = 14'(i % 3);
      io_qpi_rd_rsp_data = rand_line();
      #1;
      n_cmp++;
      if (io_out_valid !== 1'b0 || io_busy !== 1'b0 || io_qpi_rd_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_late_rsp cyc=%0d got out=%b busy=%b req=%b required 0/0/0",
                 i, io_out_valid, io_busy, io_qpi_rd_req_valid);
      end
    end
    io_qpi_rd_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream(20'h00100, 4, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    test_out_of_order();
    test_stream(20'h04000, 20, 1'b1, 1'b0, 1'b0, 30, -1, -1);
    test_stream(20'h05000, 6, 1'b0, 1'b0, 1'b0, 0, 2, 6);
    test_zero_lines();
    test_stream(20'hFFFFC, 9, 1'b1, 1'b1, 1'b1, 0, -1, -1);
    for (int r = 0; r < 4; r++)
      test_stream(ADDR_W'($urandom), int'($urandom_range(1, 40)), 1'(r % 2),
                  1'b1, 1'b1, 0, -1, -1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qpi_rd_stream.md
QPI_RD_STREAM -- requirements
Module: qpi_rd_stream

Interface
REQ-001 Parameter: TAGS, default 8, number of outstanding read slots; power of two, 2..64.
REQ-002 Parameter: ADDR_W, default 20, QPI cache-line address width.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: io_start  input  1  one-cycle request to begin a stream; sampled only in IDLE.
REQ-006 Port: io_base_addr  input  ADDR_W  first cache-line address; latched on accepted io_start.
REQ-007 Port: io_num_lines  input  ADDR_W  line count; latched on accepted io_start.
REQ-008 Port: io_qpi_rd_req_almostfull  input  1  QPI read request backpressure.
REQ-009 Port: io_qpi_rd_req_addr / io_qpi_rd_req_mdata / io_qpi_rd_req_valid  output  ADDR_W / 14 / 1  read request.
REQ-010 Port: io_qpi_rd_rsp_mdata / io_qpi_rd_rsp_data / io_qpi_rd_rsp_valid  input  14 / 512 / 1  read response, out of order, no backpressure.
REQ-011 Port: io_out_valid / io_out_data  output  1 / 512, and io_out_ready  input  1  in-order line stream to the graph core.
REQ-012 Port: io_busy  output  1  high outside IDLE; io_done  output  1  one-cycle completion pulse.

Function
REQ-013 FSM: IDLE -> RUN on io_start in IDLE; RUN -> DONE when issued == delivered == num_lines; DONE -> IDLE unconditionally after one cycle.
REQ-014 io_start with io_num_lines == 0: IDLE -> DONE directly, no requests issued.
REQ-015 io_start outside IDLE is ignored; latched base/count remain unchanged.
REQ-016 Request issues in a cycle iff RUN, issued < num_lines, almostfull low, and issued - delivered < TAGS.
REQ-017 Request fields: addr = base + issued (mod 2^ADDR_W); mdata = issued mod TAGS, zero-extended to 14 bits; valid is combinational from REQ-016; issued increments the same cycle.
REQ-018 Response: slot rsp_mdata[log2(TAGS)-1:0] captures data and is marked full at the next edge; a response to an already-full slot is dropped and the slot is unchanged.
REQ-019 io_out_valid = head slot full; io_out_data = head slot data; both stable while io_out_valid && !io_out_ready.
REQ-020 Pop on io_out_valid && io_out_ready: head slot cleared, head and delivered increment; the slot becomes reusable for issue in the following cycle.
REQ-021 Latency: head response arriving at edge N -> io_out_valid at N+1; max throughput 1 line/cycle.
REQ-022 Same-cycle response write to one slot and pop of another slot: both take effect.
REQ-023 io_done is high exactly in the DONE state; io_busy is high in RUN and DONE.

Reset
REQ-024 reset low: state IDLE; issued, delivered, head, and all full flags cleared; io_qpi_rd_req_valid, io_out_valid, io_done, and io_busy all 0; slot data need not be cleared.
REQ-025 reset asserted mid-stream: outstanding responses arriving after reset release are dropped, because no slot is expected.

Configuration
REQ-026 Macro QPI_RD_STREAM_PERF_EN: when defined, add output io_stall_cycles (32 bits); it is cleared on reset and on accepted io_start, and increments each RUN cycle in which issued < num_lines and a request is blocked by almostfull or a full window.
REQ-027 Without QPI_RD_STREAM_PERF_EN the port and counter do not exist; all other behaviour is identical.

Verification
REQ-028 Scenario: base=0x100, lines=4, in-order responses, ready=1 -> addrs 0x100..0x103, mdata 0..3, four outputs in order, io_done one cycle after the last pop.
REQ-029 Scenario: lines=4, responses with mdata 3,1,2,0 -> no output until tag 0 arrives, then lines 0,1,2,3 on consecutive cycles.
REQ-030 Scenario: TAGS=8, lines=20, ready=0 -> exactly 8 requests issued, then valid stays low; raising ready resumes issue one cycle after each pop.
REQ-031 Scenario: almostfull high for 5 cycles during RUN -> no requests in those cycles; with PERF_EN, io_stall_cycles == 5.
REQ-032 Scenario: lines=0 -> io_done pulses the cycle after io_start, no request valid; a second io_start while busy -> ignored.
REQ-033 Scenario: reset pulsed low with 3 requests outstanding -> all outputs 0 immediately; late responses produce no io_out_valid.
